operand_fetch: RTL and testbench

Issue stage directly upstream of `alu`. Accepts decoded-order 32-bit RV32I instructions from fetch, reads `rs1`/`rs2` from an internal 32×32 register file, and presents `instruction`, `op_a` and `op_b` to the ALU through a registered valid/ready stage. It also owns the writeback port and a per-register busy scoreboard that stalls issue on read-after-write and write-after-write hazards.

---
 rtl/operand_fetch_if.sv | 28 ++
 rtl/operand_fetch.sv | 137 +++++++++++++
 tb/tb_operand_fetch.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// rtl/operand_fetch_if.sv - fetch-side, ALU-side and writeback signals of the operand fetch stage
interface operand_fetch_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instruction;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instruction;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    // Environment side: drives instructions, ALU ready and writeback.
    modport master (
        output in_valid, in_instruction, out_ready, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, out_instruction, op_a, op_b
    );

    // Stage side.
    modport slave (
        input  in_valid, in_instruction, out_ready, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, out_instruction, op_a, op_b
    );
endinterface

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - RV32I issue stage: register file, busy scoreboard, registered ALU handoff
module operand_fetch #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    operand_fetch_if.slave bus
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [XLEN-1:0] regs_q [32];
    logic [31:0]     busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [XLEN-1:0] op_a_q, op_a_d;
    logic [XLEN-1:0] op_b_q, op_b_d;

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic        reads_rs1, reads_rs2, writes_rd;
    logic [31:0] clr;
    logic        stall, ready, accept;

    assign opcode = bus.in_instruction[6:0];
    assign rd     = bus.in_instruction[11:7];
    assign rs1    = bus.in_instruction[19:15];
    assign rs2    = bus.in_instruction[24:20];

    // Decode which register fields the opcode actually uses.
    always_comb begin
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin reads_rs1 = 1'b1; writes_rd = 1'b1; end
            OPC_OP:     begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; writes_rd = 1'b1; end
            OPC_LUI:    writes_rd = 1'b1;
            OPC_AUIPC:  writes_rd = 1'b1;
            OPC_JAL:    writes_rd = 1'b1;
            OPC_JALR:   begin reads_rs1 = 1'b1; writes_rd = 1'b1; end
            OPC_LOAD:   begin reads_rs1 = 1'b1; writes_rd = 1'b1; end
            OPC_STORE:  begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
            OPC_BRANCH: begin reads_rs1 = 1'b1; reads_rs2 = 1'b1; end
            default:    ;
        endcase
    end

    // Hazard check: a writeback landing this cycle releases its register,
    // so the waiting instruction issues now and picks the value off the bypass.
    always_comb begin
        clr = '0;
        if (bus.wb_en) begin
            clr[bus.wb_rd] = 1'b1;
        end
        stall = (reads_rs1 && busy_q[rs1] && !clr[rs1]) ||
                (reads_rs2 && busy_q[rs2] && !clr[rs2]) ||
                (writes_rd && (rd != 5'd0) && busy_q[rd] && !clr[rd]);
        ready  = !stall && (!out_valid_q || bus.out_ready);
        accept = bus.in_valid && ready;
    end

    // Operand selection with writeback bypass, and next state of the output stage.
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = bus.in_instruction;
            op_a_d      = '0;
            op_b_d      = '0;
            if (reads_rs1 && (rs1 != 5'd0)) begin
                op_a_d = (bus.wb_en && (bus.wb_rd == rs1)) ? bus.wb_data : regs_q[rs1];
            end
            if (reads_rs2 && (rs2 != 5'd0)) begin
                op_b_d = (bus.wb_en && (bus.wb_rd == rs2)) ? bus.wb_data : regs_q[rs2];
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Scoreboard: clear on writeback first so a same-cycle issue to that register wins.
    always_comb begin
        busy_d = busy_q;
        if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
            busy_d[bus.wb_rd] = 1'b0;
        end
        if (accept && writes_rd && (rd != 5'd0)) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Register file write port; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
            regs_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    // Output stage and scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
        end else begin
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
        end
    end

    assign bus.in_ready        = ready;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_instruction = out_instr_q;
    assign bus.op_a            = op_a_q;
    assign bus.op_b            = op_b_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - vector table, corner sequences and random run against a reference model
module tb_operand_fetch;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    operand_fetch_if #(.XLEN(32)) bus ();

    operand_fetch #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic        m_ov;
    logic [31:0] m_inst, m_a, m_b;

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic        ordy;
        logic        wen;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        e_ready;
        logic        e_ov;
        logic [31:0] e_a;
        logic [31:0] e_b;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] i_type(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [2:0] f3, input logic [11:0] imm);
        return {imm, rs1, f3, rd, OPC_OP_IMM};
    endfunction

    function automatic logic [31:0] lui(input logic [4:0] rd);
        return {20'h12345, rd, OPC_LUI};
    endfunction

    function automatic vec_t mk(input logic iv, input logic [31:0] instr, input logic ordy,
                                input logic wen, input logic [4:0] wrd, input logic [31:0] wdata,
                                input logic e_ready, input logic e_ov,
                                input logic [31:0] e_a, input logic [31:0] e_b);
        vec_t v;
        v.iv = iv; v.instr = instr; v.ordy = ordy;
        v.wen = wen; v.wrd = wrd; v.wdata = wdata;
        v.e_ready = e_ready; v.e_ov = e_ov; v.e_a = e_a; v.e_b = e_b;
        return v;
    endfunction

    function automatic bit uses_rs1(input logic [6:0] op);
        return op inside {OPC_OP_IMM, OPC_OP, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_BRANCH};
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return op inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    endfunction

    function automatic bit uses_rd(input logic [6:0] op);
        return op inside {OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_ov = 1'b0; m_inst = '0; m_a = '0; m_b = '0;
    endtask

    // A register is pending when busy and not being written back right now.
    function automatic bit pending(input logic [4:0] r, input logic wen, input logic [4:0] wrd);
        return (r != 0) && m_busy[r] && !(wen && wrd == r);
    endfunction

    function automatic logic [31:0] value_of(input logic [4:0] r, input logic wen,
                                             input logic [4:0] wrd, input logic [31:0] wd);
        if (r == 0) return 32'd0;
        if (wen && wrd == r) return wd;
        return m_regs[r];
    endfunction

    function automatic bit model_ready(input logic [31:0] instr, input logic ordy,
                                       input logic wen, input logic [4:0] wrd);
        bit hz;
        hz = (uses_rs1(instr[6:0]) && pending(instr[19:15], wen, wrd)) ||
             (uses_rs2(instr[6:0]) && pending(instr[24:20], wen, wrd)) ||
             (uses_rd(instr[6:0])  && pending(instr[11:7],  wen, wrd));
        return !hz && (!m_ov || ordy);
    endfunction

    // One clock: apply inputs, check in_ready before the edge, check outputs after it.
    task automatic cycle(input logic iv, input logic [31:0] instr, input logic ordy,
                         input logic wen, input logic [4:0] wrd, input logic [31:0] wdata,
                         output logic a_ready, output logic a_ov,
                         output logic [31:0] a_a, output logic [31:0] a_b);
        bit er, acc;
        bus.in_valid = iv; bus.in_instruction = instr; bus.out_ready = ordy;
        bus.wb_en = wen; bus.wb_rd = wrd; bus.wb_data = wdata;
        #2;
        er = model_ready(instr, ordy, wen, wrd);
        a_ready = bus.in_ready;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, er});
        acc = iv && er;
        @(posedge clk);
        if (acc) begin
            m_ov = 1'b1;
            m_inst = instr;
            m_a = uses_rs1(instr[6:0]) ? value_of(instr[19:15], wen, wrd, wdata) : 32'd0;
            m_b = uses_rs2(instr[6:0]) ? value_of(instr[24:20], wen, wrd, wdata) : 32'd0;
        end else if (m_ov && ordy) begin
            m_ov = 1'b0;
        end
        if (wen && wrd != 0) begin
            m_regs[wrd] = wdata;
            m_busy[wrd] = 1'b0;
        end
        if (acc && uses_rd(instr[6:0]) && instr[11:7] != 0) begin
            m_busy[instr[11:7]] = 1'b1;
        end
        #1;
        a_ov = bus.out_valid; a_a = bus.op_a; a_b = bus.op_b;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
        chk("out_instruction", bus.out_instruction, m_inst);
        chk("op_a", bus.op_a, m_a);
        chk("op_b", bus.op_b, m_b);
    endtask

    initial begin
        logic        r_ready, r_ov;
        logic [31:0] r_a, r_b;
        logic [31:0] ri;
        logic [6:0]  ops [10];

        bus.in_valid = 1'b0; bus.in_instruction = '0; bus.out_ready = 1'b1;
        bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        model_reset();

        // Reset state.
        @(posedge clk); @(posedge clk); #1;
        chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset out_instruction", bus.out_instruction, 32'd0);
        chk("reset op_a", bus.op_a, 32'd0);
        chk("reset op_b", bus.op_b, 32'd0);
        chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;

        //            iv  instr                           ordy wen wrd    wdata          rdy ov  op_a           op_b
        tbl[0]  = mk(0, 32'd0,                             1, 1, 5'd5,  32'h1234_5678, 1, 0, 32'd0,         32'd0);
        tbl[1]  = mk(1, r_type(5'd6, 5'd5, 5'd0),          1, 0, 5'd0,  32'd0,         1, 1, 32'h1234_5678, 32'd0);
        tbl[2]  = mk(1, i_type(5'd1, 5'd0, 3'd0, 12'd1),   1, 0, 5'd0,  32'd0,         1, 1, 32'd0,         32'd0);
        tbl[3]  = mk(1, i_type(5'd2, 5'd1, 3'd0, 12'd1),   1, 0, 5'd0,  32'd0,         0, 0, 32'd0,         32'd0);
        tbl[4]  = mk(1, i_type(5'd2, 5'd1, 3'd0, 12'd1),   1, 1, 5'd1,  32'd1,         1, 1, 32'd1,         32'd0);
        tbl[5]  = mk(1, lui(5'd3),                         1, 0, 5'd0,  32'd0,         1, 1, 32'd0,         32'd0);
        tbl[6]  = mk(1, lui(5'd3),                         1, 0, 5'd0,  32'd0,         0, 0, 32'd0,         32'd0);
        tbl[7]  = mk(1, lui(5'd3),                         1, 1, 5'd3,  32'h0000_AAAA, 1, 1, 32'd0,         32'd0);
        tbl[8]  = mk(1, lui(5'd3),                         1, 0, 5'd0,  32'd0,         0, 0, 32'd0,         32'd0);
        tbl[9]  = mk(0, 32'd0,                             1, 1, 5'd3,  32'h0000_BBBB, 1, 0, 32'd0,         32'd0);
        tbl[10] = mk(1, r_type(5'd7, 5'd1, 5'd5),          0, 0, 5'd0,  32'd0,         1, 1, 32'd1,         32'h1234_5678);
        tbl[11] = mk(1, r_type(5'd8, 5'd1, 5'd1),          0, 0, 5'd0,  32'd0,         0, 1, 32'd1,         32'h1234_5678);
        tbl[12] = mk(1, r_type(5'd8, 5'd1, 5'd1),          0, 0, 5'd0,  32'd0,         0, 1, 32'd1,         32'h1234_5678);
        tbl[13] = mk(1, r_type(5'd8, 5'd1, 5'd1),          0, 0, 5'd0,  32'd0,         0, 1, 32'd1,         32'h1234_5678);
        tbl[14] = mk(1, r_type(5'd8, 5'd1, 5'd1),          1, 0, 5'd0,  32'd0,         1, 1, 32'd1,         32'd1);
        tbl[15] = mk(0, 32'd0,                             1, 1, 5'd0,  32'hFFFF_FFFF, 1, 0, 32'd1,         32'd1);
        tbl[16] = mk(1, i_type(5'd9, 5'd0, 3'd2, 12'd5),   1, 0, 5'd0,  32'd0,         1, 1, 32'd0,         32'd0);
        tbl[17] = mk(1, i_type(5'd10, 5'd0, 3'd2, 12'hFFF),1, 1, 5'd0,  32'hFFFF_FFFF, 1, 1, 32'd0,         32'd0);

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].iv, tbl[i].instr, tbl[i].ordy, tbl[i].wen, tbl[i].wrd, tbl[i].wdata,
                  r_ready, r_ov, r_a, r_b);
            chk($sformatf("vec%0d in_ready", i), {31'd0, r_ready}, {31'd0, tbl[i].e_ready});
            chk($sformatf("vec%0d out_valid", i), {31'd0, r_ov}, {31'd0, tbl[i].e_ov});
            chk($sformatf("vec%0d op_a", i), r_a, tbl[i].e_a);
            chk($sformatf("vec%0d op_b", i), r_b, tbl[i].e_b);
        end

        // Reset while holding a valid output and with x7 busy.
        bus.in_valid = 1'b1; bus.in_instruction = r_type(5'd12, 5'd7, 5'd0);
        bus.out_ready = 1'b0; bus.wb_en = 1'b0;
        #2;
        chk("pre-reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("async reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("async reset op_a", bus.op_a, 32'd0);
        chk("async reset out_instruction", bus.out_instruction, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        cycle(1, r_type(5'd11, 5'd7, 5'd5), 1, 0, 5'd0, 32'd0, r_ready, r_ov, r_a, r_b);
        chk("post-reset accept", {31'd0, r_ready}, 32'd1);
        chk("post-reset out_valid", {31'd0, r_ov}, 32'd1);
        chk("post-reset op_a", r_a, 32'd0);
        chk("post-reset op_b", r_b, 32'd0);

        // Randomised traffic on a small register window to provoke hazards.
        ops = '{OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL,
                OPC_JALR, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_SYSTEM};
        for (int n = 0; n < 600; n++) begin
            ri = $urandom;
            ri[6:0]   = ops[$urandom_range(0, 9)];
            ri[11:7]  = 5'($urandom_range(0, 7));
            ri[19:15] = 5'($urandom_range(0, 7));
            ri[24:20] = 5'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 3) != 0), ri, 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  r_ready, r_ov, r_a, r_b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
